// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
//
// APB completer for one PSEL slot of the AHB-APB bridge. It holds a
// word-addressed register file of DEPTH registers starting at BASE_ADDR. Each
// access gets WAIT_CYCLES wait states before PREADY. Bad addresses are
// answered with PSLVERR.
//
// Optional feature (macro APB_SLV_PSTRB_EN):
//   defined   -> PSTRB port exists; writes update only the strobed bytes.
//   undefined -> no PSTRB port; every write updates the full word.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   PSEL       in   slave select
//   PENABLE    in   access-phase indicator
//   PWRITE     in   1 = write, 0 = read
//   PADDR      in   byte address            [ADDR_W-1:0]
//   PWDATA     in   write data              [DATA_W-1:0]
//   PSTRB      in   byte write strobes      [DATA_W/8-1:0] (APB_SLV_PSTRB_EN only)
//   PRDATA     out  read data, valid while PREADY=1
//   PREADY     out  transfer complete (one-cycle pulse)
//   PSLVERR    out  transfer error, valid while PREADY=1
//   fsm_state  out  current FSM state (0=IDLE, 1=WAIT, 2=RESP), for observation
//
// Handshake: a transfer begins when the setup phase (PSEL=1, PENABLE=0) is
// sampled in IDLE. The transfer completes on the rising edge where PREADY=1
// is seen. PRDATA and PSLVERR are meaningful only in that cycle and are 0
// otherwise. All outputs are registered.
// -----------------------------------------------------------------------------
module apb_slave_regfile #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_W-1:0]     PADDR,
  input  logic [DATA_W-1:0]     PWDATA,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_W/8-1:0]   PSTRB,
`endif
  output logic [DATA_W-1:0]     PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [1:0]            fsm_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               pready_nx;
  logic               pslverr_nx;
  logic [DATA_W-1:0]  prdata_nx;
  logic               setup_take;
  logic               commit;

  // Transfer attributes captured at the setup edge; bus changes afterwards
  // do not affect the transfer.
  logic               lat_write;
  logic               lat_err;
  logic [IDX_W-1:0]   lat_idx;
  logic [DATA_W-1:0]  lat_wdata;
  logic [DATA_W-1:0]  lat_rdata;
  logic [STRB_W-1:0]  wr_mask;
`ifdef APB_SLV_PSTRB_EN
  logic [STRB_W-1:0]  lat_strb;
`endif

  logic [DATA_W-1:0]  regs [DEPTH];

  // Address decode
  logic [ADDR_W-1:0]  offset;
  logic [IDX_W-1:0]   dec_idx;
  logic               dec_err;
  logic [DATA_W-1:0]  setup_rdata;

  always_comb begin
    offset  = PADDR - BASE_ADDR;
    dec_idx = offset[IDX_W+1:2];
    dec_err = (PADDR < BASE_ADDR)
           || ((offset >> 2) >= ADDR_W'(DEPTH))
           || (PADDR[1:0] != 2'b00);
    // Reads capture register contents at the setup edge. Errored accesses
    // and writes return zero.
    setup_rdata = (!PWRITE && !dec_err) ? regs[dec_idx] : '0;
  end

  always_comb begin
`ifdef APB_SLV_PSTRB_EN
    wr_mask = lat_strb;
`else
    wr_mask = '1;
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pready_nx  = 1'b0;
    pslverr_nx = 1'b0;
    prdata_nx  = '0;
    setup_take = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        // PENABLE=1 without a preceding setup phase is ignored.
        if (PSEL && !PENABLE) begin
          setup_take = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nx   = S_RESP;
            pready_nx  = 1'b1;
            pslverr_nx = dec_err;
            prdata_nx  = setup_rdata;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          // The master abandoned the transfer: drop it silently.
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (PENABLE) begin
          if (cnt == '0) begin
            state_nx   = S_RESP;
            pready_nx  = 1'b1;
            pslverr_nx = lat_err;
            prdata_nx  = lat_rdata;
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
      end
      S_RESP: begin
        // The master samples PREADY on this edge, which completes the
        // transfer. A write takes effect here.
        commit   = lat_write && !lat_err;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State, output and register-file storage
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      PRDATA    <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_rdata <= '0;
`ifdef APB_SLV_PSTRB_EN
      lat_strb  <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      PREADY  <= pready_nx;
      PSLVERR <= pslverr_nx;
      PRDATA  <= prdata_nx;
      if (setup_take) begin
        lat_write <= PWRITE;
        lat_err   <= dec_err;
        lat_idx   <= dec_idx;
        lat_wdata <= PWDATA;
        lat_rdata <= setup_rdata;
`ifdef APB_SLV_PSTRB_EN
        lat_strb  <= PSTRB;
`endif
      end
      if (commit) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_mask[b]) begin
            regs[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regfile
//
// Directed bench for apb_slave_regfile. There are three instances, which
// share the clock, reset and bus, and each has its own PSEL:
//   dut index 0 : WAIT_CYCLES = 0
//   dut index 1 : WAIT_CYCLES = 3
//   dut index 2 : WAIT_CYCLES = 2
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_apb_slave_regfile;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- bus ----------------
  logic [2:0]       psel    = '0;
  logic             penable = 1'b0;
  logic             pwrite  = 1'b0;
  logic [31:0]      paddr   = '0;
  logic [31:0]      pwdata  = '0;
`ifdef APB_SLV_PSTRB_EN
  logic [3:0]       pstrb   = '0;
`endif
  logic [2:0]       pready;
  logic [2:0]       pslverr;
  logic [2:0][31:0] prdata;
  logic [2:0][1:0]  fsm;

  apb_slave_regfile #(.WAIT_CYCLES(0)) u_dut0 (
    .clock(clock), .reset(reset), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
    .fsm_state(fsm[0])
  );

  apb_slave_regfile #(.WAIT_CYCLES(3)) u_dut1 (
    .clock(clock), .reset(reset), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
    .fsm_state(fsm[1])
  );

  apb_slave_regfile #(.WAIT_CYCLES(2)) u_dut2 (
    .clock(clock), .reset(reset), .PSEL(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]),
    .fsm_state(fsm[2])
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model0 [16];

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  // ---------------- driver tasks ----------------
  // Runs the setup phase and then access cycles until PREADY is seen, with a
  // bound on the wait. It returns at the falling edge where PREADY=1 is
  // sampled and leaves PSEL/PENABLE asserted through the completing edge.
  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic err,
                          output int waits);
    @(negedge clock);
    check($sformatf("pready_low_before_setup_d%0d", d), 32'(pready[d]), 32'd0);
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
`ifdef APB_SLV_PSTRB_EN
    pstrb   = strb;
`endif
    @(negedge clock);
    penable = 1'b1;
    waits   = 0;
    while (!pready[d] && waits < 32) begin
      waits++;
      @(negedge clock);
    end
    if (!pready[d]) check("ready_timeout", 32'(pready[d]), 32'd1);
    rdata = prdata[d];
    err   = pslverr[d];
  endtask

  // Returns the bus to idle and confirms that PREADY was a single-cycle pulse.
  task automatic bus_idle(input int d);
    @(negedge clock);
    psel    = '0;
    penable = 1'b0;
    check($sformatf("pready_pulse_d%0d", d), 32'(pready[d]), 32'd0);
    check($sformatf("fsm_idle_d%0d", d), 32'(fsm[d]), 32'd0);
  endtask

  task automatic do_write(input int d, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input logic exp_err, input int exp_waits,
                          input string tag);
    logic [31:0] rd;
    logic        er;
    int          w;
    apb_xfer(d, 1'b1, addr, data, strb, rd, er, w);
    check({tag, "_waits"},  32'(w),  32'(exp_waits));
    check({tag, "_err"},    32'(er), 32'(exp_err));
    check({tag, "_prdata"}, rd,      32'd0);
  endtask

  task automatic do_read(input int d, input logic [31:0] addr,
                         input logic exp_err, input int exp_waits,
                         input string tag);
    logic [31:0] rd;
    logic        er;
    int          w;
    apb_xfer(d, 1'b0, addr, 32'h0, 4'h0, rd, er, w);
    check({tag, "_waits"}, 32'(w),  32'(exp_waits));
    check({tag, "_err"},   32'(er), 32'(exp_err));
    check({tag, "_data"},  rd,      exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 16; i++) model0[i] = 32'h0;

    // Reset
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_pready",  32'(pready[0]),  32'd0);
    check("rst_pslverr", 32'(pslverr[0]), 32'd0);
    check("rst_prdata",  prdata[0],       32'd0);
    check("rst_fsm",     32'(fsm[0]),     32'd0);

    // T1: write then back-to-back read, with no wait states
    do_write(0, 32'h08, 32'hDEAD_BEEF, 4'hF, 1'b0, 0, "t1_wr");
    model0[2] = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    do_read(0, 32'h08, 1'b0, 0, "t1_rd");
    // Last valid register
    do_write(0, 32'h3C, 32'h1234_5678, 4'hF, 1'b0, 0, "last_wr");
    model0[15] = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    do_read(0, 32'h3C, 1'b0, 0, "last_rd");
    bus_idle(0);

    // T2: three wait states
    exp_q.push_back(32'h0);
    do_read(1, 32'h04, 1'b0, 3, "t2_rd");
    do_write(1, 32'h04, 32'hCAFE_F00D, 4'hF, 1'b0, 3, "t2_wr");
    exp_q.push_back(32'hCAFE_F00D);
    do_read(1, 32'h04, 1'b0, 3, "t2_rd2");
    bus_idle(1);

    // T3: decode errors, then a full read-back
    do_write(0, 32'h40, 32'h11, 4'hF, 1'b1, 0, "t3_wr_range");
    do_write(0, 32'h06, 32'h11, 4'hF, 1'b1, 0, "t3_wr_misal");
    exp_q.push_back(32'h0);
    do_read(0, 32'h40, 1'b1, 0, "t3_rd_range");
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(model0[i]);
      do_read(0, 32'(i * 4), 1'b0, 0, $sformatf("t3_rb_%02h", i * 4));
    end
    bus_idle(0);

    // T4: the master drops PSEL while the slave is waiting
    @(negedge clock);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h0C; pwdata = 32'h55;
    @(negedge clock);
    penable = 1'b1;
    check("t4_access1_pready", 32'(pready[2]), 32'd0);
    @(negedge clock);
    psel = '0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("t4_abort_pready_%0d", i), 32'(pready[2]), 32'd0);
      check($sformatf("t4_abort_fsm_%0d", i),    32'(fsm[2]),    32'd0);
    end
    exp_q.push_back(32'h0);
    do_read(2, 32'h0C, 1'b0, 2, "t4_rd");
    bus_idle(2);

`ifdef APB_SLV_PSTRB_EN
    // T6: byte strobes
    do_write(0, 32'h00, 32'hFFFF_FFFF, 4'b0101, 1'b0, 0, "t6_wr");
    exp_q.push_back(32'h00FF_00FF);
    do_read(0, 32'h00, 1'b0, 0, "t6_rd");
    do_write(0, 32'h00, 32'h1234_5678, 4'b0000, 1'b0, 0, "t6_wr_nostrb");
    exp_q.push_back(32'h00FF_00FF);
    do_read(0, 32'h00, 1'b0, 0, "t6_rd2");
    bus_idle(0);
`endif

    // T5: reset while a write is in its wait states
    @(negedge clock);
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h10; pwdata = 32'hA5A5_A5A5;
    @(negedge clock);
    penable = 1'b1;
    @(negedge clock);
    check("t5_pre_fsm_wait", 32'(fsm[1]), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("t5_rst_pready",  32'(pready[1]),  32'd0);
    check("t5_rst_pslverr", 32'(pslverr[1]), 32'd0);
    check("t5_rst_prdata",  prdata[1],       32'd0);
    check("t5_rst_fsm",     32'(fsm[1]),     32'd0);
    reset = 1'b0; psel = '0; penable = 1'b0;
    exp_q.push_back(32'h0);
    do_read(1, 32'h10, 1'b0, 3, "t5_rd");
    bus_idle(1);

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
